seg_display_scheduler: RTL and testbench

- Time-multiplexes one shared registered hex-to-7-segment decoder across NUM_DIGITS common-pin digits.
- Takes received bytes (UART RX data-valid strobe plus byte) into a nibble buffer.
- Sequences the decoder once per digit slot, with a blanking gap between slots to prevent ghosting.
- Sits between the UART receiver and the board display pins.

---
 rtl/seg_pkg.sv | 20 ++
 rtl/seg_nibble_buffer.sv | 34 +++
 rtl/seg_display_scheduler.sv | 94 +++++++++
 tb/tb_seg_display_scheduler.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed seven-segment display scheduler.
package seg_pkg;

  localparam int unsigned SEG_W    = 7;
  localparam int unsigned NIBBLE_W = 4;

  // Segment bit positions within a {A,B,C,D,E,F,G} pattern
  localparam int unsigned SEG_A = 6;
  localparam int unsigned SEG_B = 5;
  localparam int unsigned SEG_C = 4;
  localparam int unsigned SEG_D = 3;
  localparam int unsigned SEG_E = 2;
  localparam int unsigned SEG_F = 1;
  localparam int unsigned SEG_G = 0;

  typedef logic [0:0] state_t;
  localparam state_t S_BLANK = 1'b0;
  localparam state_t S_DRIVE = 1'b1;

endpackage

// File: rtl/seg_nibble_buffer.sv
// Nibble storage for the display: byte-wide left shift, clear, and one read port.
module seg_nibble_buffer
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 2,
  localparam int unsigned IDX_W = $clog2(NUM_DIGITS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr,
  input  logic [7:0]          wr_byte,
  input  logic                clear,
  input  logic [IDX_W-1:0]    rd_idx,
  output logic [NIBBLE_W-1:0] rd_nibble
);

  logic [NIBBLE_W-1:0] nib_q [NUM_DIGITS];

  // Clear wins over a same-cycle write; a write pushes the byte in at the right
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_DIGITS; k++) nib_q[k] <= '0;
    end else if (clear) begin
      for (int k = 0; k < NUM_DIGITS; k++) nib_q[k] <= '0;
    end else if (wr) begin
      for (int k = NUM_DIGITS - 1; k >= 2; k--) nib_q[k] <= nib_q[k-2];
      nib_q[1] <= wr_byte[7:4];
      nib_q[0] <= wr_byte[3:0];
    end
  end

  assign rd_nibble = nib_q[rd_idx];

endmodule

// File: rtl/seg_display_scheduler.sv
// Time-multiplexes one shared registered hex decoder across NUM_DIGITS digits,
// with a blanking gap at the start of every digit slot.
module seg_display_scheduler
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 2,
  parameter int unsigned SLOT_CYCLES  = 25000,
  parameter int unsigned BLANK_CYCLES = 250
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst,
  input  logic                  i_Wr_DV,
  input  logic [7:0]            i_Wr_Byte,
  input  logic                  i_Clear,
  input  logic                  i_Enable,
  output logic [NIBBLE_W-1:0]   o_Dec_Nibble,
  input  logic [SEG_W-1:0]      i_Dec_Seg,
  output logic [SEG_W-1:0]      o_Segment,
  output logic [NUM_DIGITS-1:0] o_Digit_En,
  output logic                  o_Slot_Start
);

  localparam int unsigned CNT_W = $clog2(SLOT_CYCLES);
  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [SEG_W-1:0]        seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   en_q, en_d;
  logic                    start_q, start_d;
  logic                    cnt_last, blank_last;

  seg_nibble_buffer #(.NUM_DIGITS(NUM_DIGITS)) u_buffer (
    .clk       (i_Clk),
    .rst       (i_Rst),
    .wr        (i_Wr_DV),
    .wr_byte   (i_Wr_Byte),
    .clear     (i_Clear),
    .rd_idx    (idx_q),
    .rd_nibble (o_Dec_Nibble)
  );

  assign cnt_last   = (cnt_q == CNT_W'(SLOT_CYCLES - 1));
  assign blank_last = (cnt_q == CNT_W'(BLANK_CYCLES - 1));

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q <= S_BLANK;
      cnt_q   <= '0;
      idx_q   <= '0;
      seg_q   <= '0;
      en_q    <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      en_q    <= en_d;
      start_q <= start_d;
    end
  end

  // Segment capture happens on the last blank cycle so the decoder has settled
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_last ? '0 : cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    seg_d   = seg_q;
    en_d    = '0;
    start_d = cnt_last;
    case (state_q)
      S_BLANK: begin
        if (blank_last) begin
          seg_d   = i_Dec_Seg;
          state_d = S_DRIVE;
        end
      end
      default: begin
        if (cnt_last) begin
          idx_d   = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
          state_d = S_BLANK;
        end
      end
    endcase
    if (state_d == S_DRIVE && i_Enable) en_d[idx_q] = 1'b1;
  end

  assign o_Segment    = seg_q;
  assign o_Digit_En   = en_q;
  assign o_Slot_Start = start_q;

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Randomized self-checking bench for seg_display_scheduler against a slot-arithmetic model.
module tb_seg_display_scheduler;

  localparam int unsigned N     = 2;
  localparam int unsigned SLOT  = 8;
  localparam int unsigned BLANK = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         wr_dv = 1'b0;
  logic [7:0]   wr_byte = '0;
  logic         clr = 1'b0;
  logic         en = 1'b1;
  logic [3:0]   dec_nib;
  logic [6:0]   dec_seg = '0;
  logic [6:0]   seg;
  logic [N-1:0] dig_en;
  logic         slot_start;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: cycle index since reset release plus buffer contents
  int         cyc;
  logic [3:0] mbuf [N];
  logic [6:0] seg_hold;
  logic [6:0] snap;
  logic       en_prev;

  seg_display_scheduler #(.NUM_DIGITS(N), .SLOT_CYCLES(SLOT), .BLANK_CYCLES(BLANK)) dut (
    .i_Clk        (clk),
    .i_Rst        (rst),
    .i_Wr_DV      (wr_dv),
    .i_Wr_Byte    (wr_byte),
    .i_Clear      (clr),
    .i_Enable     (en),
    .o_Dec_Nibble (dec_nib),
    .i_Dec_Seg    (dec_seg),
    .o_Segment    (seg),
    .o_Digit_En   (dig_en),
    .o_Slot_Start (slot_start)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h7E; 4'h1: hex7 = 7'h30; 4'h2: hex7 = 7'h6D; 4'h3: hex7 = 7'h79;
      4'h4: hex7 = 7'h33; 4'h5: hex7 = 7'h5B; 4'h6: hex7 = 7'h5F; 4'h7: hex7 = 7'h70;
      4'h8: hex7 = 7'h7F; 4'h9: hex7 = 7'h7B; 4'hA: hex7 = 7'h77; 4'hB: hex7 = 7'h1F;
      4'hC: hex7 = 7'h4E; 4'hD: hex7 = 7'h3D; 4'hE: hex7 = 7'h4F; default: hex7 = 7'h47;
    endcase
  endfunction

  // External shared decoder: one-cycle registered lookup
  always_ff @(posedge clk) dec_seg <= hex7(dec_nib);

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    cyc = 0;
    for (int k = 0; k < N; k++) mbuf[k] = '0;
    seg_hold = '0;
    snap     = '0;
    en_prev  = 1'b0;
  endtask

  // One clock: check outputs for the current cycle, apply inputs, advance model
  task automatic step(input logic w, input logic [7:0] b, input logic c);
    int pos, idx;
    logic [N-1:0] exp_en;
    pos = cyc % SLOT;
    idx = (cyc / SLOT) % N;
    exp_en = '0;
    if (pos >= BLANK && en_prev) exp_en[idx] = 1'b1;
    check("nibble", 8'(dec_nib), 8'(mbuf[idx]));
    check("digit_en", 8'(dig_en), 8'(exp_en));
    check("segment", 8'(seg), 8'(pos >= BLANK ? seg_hold : seg_hold));
    check("slot_start", 8'(slot_start), 8'(pos == 0 && cyc != 0));
    if (pos == BLANK - 2) snap = hex7(mbuf[idx]);
    wr_dv = w; wr_byte = b; clr = c;
    @(posedge clk);
    if (pos == BLANK - 1) seg_hold = snap;
    if (c) begin
      for (int k = 0; k < N; k++) mbuf[k] = '0;
    end else if (w) begin
      for (int k = N - 1; k >= 2; k--) mbuf[k] = mbuf[k-2];
      mbuf[1] = b[7:4];
      mbuf[0] = b[3:0];
    end
    en_prev = en;
    cyc++;
    @(negedge clk);
    wr_dv = 1'b0; clr = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_segment", 8'(seg), 8'h00);
    check("rst_digit_en", 8'(dig_en), 8'h00);
    check("rst_nibble", 8'(dec_nib), 8'h00);
    check("rst_slot_start", 8'(slot_start), 8'h00);
    rst = 1'b0;

    idle(32);
    check("idle_zero_glyph", 8'(seg), 8'h7E);

    step(1'b1, 8'hA5, 1'b0);
    idle(17);

    while (!((cyc % SLOT) == 4 && ((cyc / SLOT) % N) == 0)) idle(1);
    step(1'b1, 8'h3C, 1'b0);
    idle(24);

    step(1'b1, 8'hFF, 1'b1);
    idle(16);

    en = 1'b0;
    idle(20);
    en = 1'b1;
    idle(16);

    for (int i = 0; i < 300; i++) begin
      en = ($urandom_range(0, 7) != 0);
      step($urandom_range(0, 5) == 0, 8'($urandom), $urandom_range(0, 40) == 0);
    end
    en = 1'b1;
    idle(16);

    while (!((cyc % SLOT) == 5 && ((cyc / SLOT) % N) == 1)) idle(1);
    check("pre_rst_digit_en", 8'(dig_en), 8'h02);
    rst = 1'b1;
    #1;
    check("mid_rst_digit_en", 8'(dig_en), 8'h00);
    check("mid_rst_segment", 8'(seg), 8'h00);
    check("mid_rst_slot_start", 8'(slot_start), 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("mid_rst_nibble", 8'(dec_nib), 8'h00);
    model_reset();
    rst = 1'b0;
    idle(24);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
